// File: rtl/lc4_trace_recorder_pkg.sv
// Shared definitions for the LC4 commit-trace recorder: record geometry,
// word indices, flag-word bit layout and the stall-cause encoding.
package lc4_trace_recorder_pkg;

  localparam int WORDS = 6;
  localparam int REC_W = 96;

  localparam logic [2:0] W_PC        = 3'd0;
  localparam logic [2:0] W_INSN      = 3'd1;
  localparam logic [2:0] W_RF_DATA   = 3'd2;
  localparam logic [2:0] W_DMEM_ADDR = 3'd3;
  localparam logic [2:0] W_DMEM_DATA = 3'd4;
  localparam logic [2:0] W_FLAGS     = 3'd5;

  localparam int FLAG_DMEM_WE  = 0;
  localparam int FLAG_NZP_LSB  = 1;
  localparam int FLAG_NZP_WE   = 4;
  localparam int FLAG_WSEL_LSB = 5;
  localparam int FLAG_RF_WE    = 8;

  typedef enum logic [1:0] {
    STALL_EXEC   = 2'd0,
    STALL_CACHE  = 2'd1,
    STALL_BRANCH = 2'd2,
    STALL_LOAD   = 2'd3
  } stall_e;

  // Build the write-enable/select summary word (upper seven bits always zero).
  function automatic logic [15:0] flag_word(input logic       rf_we,
                                            input logic [2:0] wsel,
                                            input logic       nzp_we,
                                            input logic [2:0] nzp,
                                            input logic       dmem_we);
    logic [15:0] f;
    f = '0;
    f[FLAG_DMEM_WE]       = dmem_we;
    f[FLAG_NZP_LSB +: 3]  = nzp;
    f[FLAG_NZP_WE]        = nzp_we;
    f[FLAG_WSEL_LSB +: 3] = wsel;
    f[FLAG_RF_WE]         = rf_we;
    return f;
  endfunction

endpackage

// File: rtl/lc4_trace_recorder_fifo.sv
// Record FIFO for the trace recorder. Pointers carry one extra wrap bit so
// that full and empty are distinguished by the pointer difference. Storage is
// not reset; only the pointers are. The head is read combinationally so a
// record pushed at one edge is presented the following cycle.
module lc4_trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      count;

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr_reg[AW-1:0]];

  // Write the incoming record into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Advance pointers; they wrap naturally through the extra bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/lc4_trace_recorder.sv
// LC4 commit-trace recorder: captures one 96-bit record per retired
// instruction, buffers it and serialises it as six 16-bit words over a
// valid/ready link. Define LC4_TRACE_STATS_EN to build the cycle/stall
// statistics counters; otherwise the stat_* ports read as zero.
module lc4_trace_recorder
  import lc4_trace_recorder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic             trace_en,
  input  logic [1:0]       test_stall,
  input  logic [15:0]      test_cur_pc,
  input  logic [15:0]      test_cur_insn,
  input  logic             test_regfile_we,
  input  logic [2:0]       test_regfile_wsel,
  input  logic [15:0]      test_regfile_data,
  input  logic             test_nzp_we,
  input  logic [2:0]       test_nzp_new_bits,
  input  logic             test_dmem_we,
  input  logic [15:0]      test_dmem_addr,
  input  logic [15:0]      test_dmem_data,
  output logic [15:0]      out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] stat_cycles,
  output logic [CNT_W-1:0] stat_exec,
  output logic [CNT_W-1:0] stat_cache,
  output logic [CNT_W-1:0] stat_branch,
  output logic [CNT_W-1:0] stat_load
);

  logic [REC_W-1:0] rec;
  logic [REC_W-1:0] head;
  logic             full;
  logic             empty;
  logic             cap;
  logic             xfer;
  logic             pop;
  logic             push;
  logic             drop;
  logic [2:0]       idx_reg;
  logic [15:0]      last_word_reg;
  logic [15:0]      head_word;

  assign rec = {flag_word(test_regfile_we, test_regfile_wsel, test_nzp_we,
                          test_nzp_new_bits, test_dmem_we),
                test_dmem_data, test_dmem_addr, test_regfile_data,
                test_cur_insn, test_cur_pc};

  // Full is judged on the pre-pop occupancy; a coincident last-word pop frees a slot.
  assign cap  = gwe & trace_en & (test_stall == STALL_EXEC);
  assign xfer = out_valid & out_ready;
  assign pop  = xfer & (idx_reg == W_FLAGS);
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  lc4_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rec),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Pick the current word of the head record.
  always_comb begin
    head_word = head[15:0];
    case (idx_reg)
      W_PC:        head_word = head[15:0];
      W_INSN:      head_word = head[31:16];
      W_RF_DATA:   head_word = head[47:32];
      W_DMEM_ADDR: head_word = head[63:48];
      W_DMEM_DATA: head_word = head[79:64];
      W_FLAGS:     head_word = head[95:80];
      default:     head_word = head[15:0];
    endcase
  end

  assign out_valid = ~empty;
  assign out_data  = out_valid ? head_word : last_word_reg;
  assign out_last  = out_valid & (idx_reg == W_FLAGS);

  // Word index walks 0..5 per record; the last transferred word is kept for idle periods.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg       <= '0;
      last_word_reg <= '0;
    end else if (xfer) begin
      idx_reg       <= pop ? 3'd0 : idx_reg + 3'd1;
      last_word_reg <= head_word;
    end
  end

  // Sticky overflow flag and saturating count of records lost to a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

`ifdef LC4_TRACE_STATS_EN
  logic [CNT_W-1:0] cycles_reg;

  // Saturating count of gwe-qualified cycles, regardless of trace_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycles_reg <= '0;
    else if (gwe && cycles_reg != '1) cycles_reg <= cycles_reg + 1'b1;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_stall_cnt
    logic [CNT_W-1:0] cnt_reg;
    // Saturating count of gwe cycles carrying this stall cause.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_reg <= '0;
      else if (gwe && test_stall == 2'(gi) && cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign stat_cycles = cycles_reg;
  assign stat_exec   = g_stall_cnt[0].cnt_reg;
  assign stat_cache  = g_stall_cnt[1].cnt_reg;
  assign stat_branch = g_stall_cnt[2].cnt_reg;
  assign stat_load   = g_stall_cnt[3].cnt_reg;
`else
  assign stat_cycles = '0;
  assign stat_exec   = '0;
  assign stat_cache  = '0;
  assign stat_branch = '0;
  assign stat_load   = '0;
`endif

endmodule

// File: tb/tb_lc4_trace_recorder.sv
// Self-checking bench for lc4_trace_recorder: directed scenarios plus a
// randomized phase, all checked every cycle against a record-queue model.
module tb_lc4_trace_recorder;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gwe, trace_en, out_ready;
  logic [1:0]  test_stall;
  logic [15:0] test_cur_pc, test_cur_insn, test_regfile_data;
  logic [15:0] test_dmem_addr, test_dmem_data;
  logic        test_regfile_we, test_nzp_we, test_dmem_we;
  logic [2:0]  test_regfile_wsel, test_nzp_new_bits;
  logic [15:0] out_data;
  logic        out_valid, out_last, overflow;
  logic [CNT_W-1:0] drop_count, stat_cycles, stat_exec, stat_cache, stat_branch, stat_load;

  always #5 clk = ~clk;

  lc4_trace_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .gwe(gwe), .trace_en(trace_en), .test_stall(test_stall),
    .test_cur_pc(test_cur_pc), .test_cur_insn(test_cur_insn),
    .test_regfile_we(test_regfile_we), .test_regfile_wsel(test_regfile_wsel),
    .test_regfile_data(test_regfile_data), .test_nzp_we(test_nzp_we),
    .test_nzp_new_bits(test_nzp_new_bits), .test_dmem_we(test_dmem_we),
    .test_dmem_addr(test_dmem_addr), .test_dmem_data(test_dmem_data),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .overflow(overflow), .drop_count(drop_count),
    .stat_cycles(stat_cycles), .stat_exec(stat_exec), .stat_cache(stat_cache),
    .stat_branch(stat_branch), .stat_load(stat_load)
  );

  // Reference model: queue of pending records (word 0 in the low 16 bits)
  logic [95:0]  mq[$];
  int           idx_m;
  logic [15:0]  last_m;
  logic         ovf_m;
  logic [31:0]  drop_m;
  logic [31:0]  st_m[5];   // cycles, exec, cache, branch, load
  int           n_vec = 0;
  int           n_err = 0;
  int           recs_seen;
  int           rec_no = 0;
  logic [15:0]  obs_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    idx_m  = 0;
    last_m = '0;
    ovf_m  = 1'b0;
    drop_m = '0;
    for (int i = 0; i < 5; i++) st_m[i] = '0;
  endtask

  function automatic logic [95:0] model_record();
    logic [15:0] flags;
    flags = {7'b0, test_regfile_we, test_regfile_wsel, test_nzp_we,
             test_nzp_new_bits, test_dmem_we};
    return {flags, test_dmem_data, test_dmem_addr, test_regfile_data,
            test_cur_insn, test_cur_pc};
  endfunction

  task automatic rand_fields();
    test_cur_pc       = 16'($urandom);
    test_cur_insn     = 16'($urandom);
    test_regfile_we   = 1'($urandom);
    test_regfile_wsel = 3'($urandom);
    test_regfile_data = 16'($urandom);
    test_nzp_we       = 1'($urandom);
    test_nzp_new_bits = 3'($urandom);
    test_dmem_we      = 1'($urandom);
    test_dmem_addr    = 16'($urandom);
    test_dmem_data    = 16'($urandom);
  endtask

  task automatic drive(input logic g, input logic en, input logic [1:0] st);
    rand_fields();
    gwe = g; trace_en = en; test_stall = st;
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic [95:0] h;
    logic [15:0] w;
    logic        valid, xfer, pop, cap, full;
    @(negedge clk);
    valid = (mq.size() > 0);
    if (valid) begin
      h = mq[0];
      w = h[idx_m*16 +: 16];
    end else begin
      w = last_m;
    end
    obs_data = out_data;
    check("out_valid",  32'(out_valid),  32'(valid));
    check("out_data",   32'(out_data),   32'(w));
    check("out_last",   32'(out_last),   32'(valid && idx_m == 5));
    check("overflow",   32'(overflow),   32'(ovf_m));
    check("drop_count", drop_count,      drop_m);
`ifdef LC4_TRACE_STATS_EN
    check("stat_cycles", stat_cycles, st_m[0]);
    check("stat_exec",   stat_exec,   st_m[1]);
    check("stat_cache",  stat_cache,  st_m[2]);
    check("stat_branch", stat_branch, st_m[3]);
    check("stat_load",   stat_load,   st_m[4]);
`else
    check("stat_cycles", stat_cycles, 32'd0);
    check("stat_exec",   stat_exec | stat_cache | stat_branch | stat_load, 32'd0);
`endif
    if (out_valid && out_ready && out_last) recs_seen++;
    xfer = valid && out_ready;
    pop  = xfer && idx_m == 5;
    cap  = gwe && trace_en && test_stall == 2'd0;
    full = (mq.size() == DEPTH);
    if (xfer) begin
      last_m = w;
      idx_m  = pop ? 0 : idx_m + 1;
    end
    if (pop) begin
      $display("rec %0d out: pc=%h insn=%h rf=%h da=%h dd=%h flags=%h", rec_no,
               h[15:0], h[31:16], h[47:32], h[63:48], h[79:64], h[95:80]);
      rec_no++;
      void'(mq.pop_front());
    end
    if (cap && full && !pop) begin
      ovf_m = 1'b1;
      if (drop_m != 32'hFFFF_FFFF) drop_m = drop_m + 1;
    end else if (cap) begin
      mq.push_back(model_record());
    end
    if (gwe) begin
      if (st_m[0] != 32'hFFFF_FFFF) st_m[0] = st_m[0] + 1;
      if (st_m[1+test_stall] != 32'hFFFF_FFFF) st_m[1+test_stall] = st_m[1+test_stall] + 1;
    end
    @(posedge clk);
    #1;
  endtask

  logic [15:0] t1_exp[6];
  logic [31:0] drop_before;
  logic [15:0] t5_pc;

  initial begin
    t1_exp = '{16'h8200, 16'h1234, 16'h00FF, 16'h0000, 16'h0000, 16'h0172};
    drive(1'b0, 1'b0, 2'd0);
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    cycle();

    // 1: single exec commit streams six words back to back
    out_ready = 1'b1;
    gwe = 1; trace_en = 1; test_stall = 2'd0;
    test_cur_pc = 16'h8200; test_cur_insn = 16'h1234;
    test_regfile_we = 1; test_regfile_wsel = 3'd3; test_regfile_data = 16'h00FF;
    test_nzp_we = 1; test_nzp_new_bits = 3'b001;
    test_dmem_we = 0; test_dmem_addr = 16'h0000; test_dmem_data = 16'h0000;
    cycle();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 2'd0);
      cycle();
      check("t1_word", 32'(obs_data), 32'(t1_exp[k]));
    end

    // 2: stall cycles interleaved with four exec commits
    recs_seen = 0;
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 1) drive(1'b1, 1'b1, 2'd0);
      else            drive(1'b1, 1'b1, 2'($urandom_range(1, 3)));
      cycle();
    end
    for (int k = 0; k < 30; k++) begin drive(1'b0, 1'b1, 2'd0); cycle(); end
    check("t2_records", 32'(recs_seen), 32'd4);

    // 3: stalled sink, DEPTH+2 commits, then drain
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) begin drive(1'b1, 1'b1, 2'd0); cycle(); end
    drive(1'b0, 1'b1, 2'd0);
    cycle();
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_drops", drop_count, 32'd2);
    out_ready = 1'b1;
    recs_seen = 0;
    for (int k = 0; k < DEPTH * 6 + 4; k++) begin drive(1'b0, 1'b1, 2'd0); cycle(); end
    check("t3_drained", 32'(recs_seen), 32'(DEPTH));

    // 6: full FIFO, commit lands on the word-5 transfer
    out_ready = 1'b0;
    recs_seen = 0;
    for (int k = 0; k < DEPTH; k++) begin drive(1'b1, 1'b1, 2'd0); cycle(); end
    drop_before = drop_m;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin drive(1'b0, 1'b1, 2'd0); cycle(); end
    drive(1'b1, 1'b1, 2'd0);
    cycle();
    check("t6_drop", drop_count, drop_before);
    for (int k = 0; k < DEPTH * 6 + 4; k++) begin drive(1'b0, 1'b1, 2'd0); cycle(); end
    check("t6_records", 32'(recs_seen), 32'(DEPTH + 1));

    // 5: reset while word 3 is presented
    drive(1'b1, 1'b1, 2'd0);
    cycle();
    for (int k = 0; k < 3; k++) begin drive(1'b0, 1'b1, 2'd0); cycle(); end
    rst = 1'b1;
    #1;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_data", 32'(out_data), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 2'd0);
    t5_pc = test_cur_pc;
    cycle();
    drive(1'b0, 1'b1, 2'd0);
    cycle();
    check("t5_w0", 32'(obs_data), 32'(t5_pc));

    // 4 + random: toggling ready and mixed commit/stall traffic
    for (int k = 0; k < 600; k++) begin
      out_ready = ($urandom_range(0, 99) < 55);
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) != 0),
            ($urandom_range(0, 99) < 45) ? 2'd0 : 2'($urandom_range(1, 3)));
      cycle();
    end
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH * 6 + 4; k++) begin drive(1'b0, 1'b1, 2'd0); cycle(); end
    check("final_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
